alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 62 ++++++
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundle of the arbiter's requester, response, ALU and
// status signals. Signal names match the original flat port list.
//   REQn_VALID/READY/A/B/INST : command handshake from requester n (n=0,1)
//   RSPn_VALID/READY/Z/FLAGS  : result handshake back to requester n
//   ALU_A/B/INST, ALU_Z/FLAGS : link to the shared ALU
//   BUSY                      : arbiter not idle
// Modports: slave = arbiter side, master = requesters + ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             REQ0_VALID;
  logic             REQ0_READY;
  logic [WIDTH-1:0] REQ0_A;
  logic [WIDTH-1:0] REQ0_B;
  logic [3:0]       REQ0_INST;
  logic             REQ1_VALID;
  logic             REQ1_READY;
  logic [WIDTH-1:0] REQ1_A;
  logic [WIDTH-1:0] REQ1_B;
  logic [3:0]       REQ1_INST;

  logic             RSP0_VALID;
  logic             RSP0_READY;
  logic [WIDTH-1:0] RSP0_Z;
  logic [3:0]       RSP0_FLAGS;
  logic             RSP1_VALID;
  logic             RSP1_READY;
  logic [WIDTH-1:0] RSP1_Z;
  logic [3:0]       RSP1_FLAGS;

  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [3:0]       ALU_INST;
  logic [WIDTH-1:0] ALU_Z;
  logic [3:0]       ALU_FLAGS;

  logic             BUSY;

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_INST,
    input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_INST,
    output REQ0_READY, REQ1_READY,
    input  RSP0_READY, RSP1_READY,
    output RSP0_VALID, RSP0_Z, RSP0_FLAGS,
    output RSP1_VALID, RSP1_Z, RSP1_FLAGS,
    output ALU_A, ALU_B, ALU_INST,
    input  ALU_Z, ALU_FLAGS,
    output BUSY
  );

  modport master (
    output REQ0_VALID, REQ0_A, REQ0_B, REQ0_INST,
    output REQ1_VALID, REQ1_A, REQ1_B, REQ1_INST,
    input  REQ0_READY, REQ1_READY,
    output RSP0_READY, RSP1_READY,
    input  RSP0_VALID, RSP0_Z, RSP0_FLAGS,
    input  RSP1_VALID, RSP1_Z, RSP1_FLAGS,
    input  ALU_A, ALU_B, ALU_INST,
    output ALU_Z, ALU_FLAGS,
    input  BUSY
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter -- shares one ALU between two requesters.
// A command accepted in IDLE is registered onto ALU_A/B/INST, held through
// EXEC (the ALU latches at the end of EXEC), the ALU result is captured in
// CAPT into the granted port's RSP_Z/FLAGS, and RESP holds RSP_VALID until
// the requester takes it. Accept at cycle t gives RSP_VALID at t+3.
// Ports:
//   CLOCK   : single clock, rising edge
//   RESET_N : synchronous active-low reset
//   bus     : alu_arbiter_if.slave (requesters, responses, ALU link, BUSY)
// Build option:
//   ALU_ARB_ROUND_ROBIN_EN defined   -> round-robin when both requesters are
//                                       valid (first grant after reset: 0)
//   ALU_ARB_ROUND_ROBIN_EN undefined -> fixed priority, port 0 wins
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_inst_q, alu_inst_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_z_q, rsp0_z_d;
  logic [WIDTH-1:0] rsp1_z_q, rsp1_z_d;
  logic [3:0]       rsp0_flags_q, rsp0_flags_d;
  logic [3:0]       rsp1_flags_q, rsp1_flags_d;

  logic sel;
  logic ready0;
  logic ready1;
  logic accept;
  logic rsp_taken;

  // Requester selection. sel=1 picks port 1. A lone valid requester always
  // wins; only a tie consults the previous grant (round-robin build).
  always_comb begin
    sel = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (bus.REQ0_VALID && bus.REQ1_VALID) begin
      sel = ~gnt_q;
    end else begin
      sel = ~bus.REQ0_VALID;
    end
`else
    sel = ~bus.REQ0_VALID;
`endif
  end

  always_comb begin
    ready0 = (state_q == IDLE) && bus.REQ0_VALID && !sel;
    ready1 = (state_q == IDLE) && bus.REQ1_VALID && sel;
    accept = ready0 || ready1;
  end

  assign rsp_taken = gnt_q ? bus.RSP1_READY : bus.RSP0_READY;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    busy_d       = busy_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_inst_d   = alu_inst_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_z_d     = rsp0_z_q;
    rsp1_z_d     = rsp1_z_q;
    rsp0_flags_d = rsp0_flags_q;
    rsp1_flags_d = rsp1_flags_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d      = sel;
          alu_a_d    = sel ? bus.REQ1_A    : bus.REQ0_A;
          alu_b_d    = sel ? bus.REQ1_B    : bus.REQ0_B;
          alu_inst_d = sel ? bus.REQ1_INST : bus.REQ0_INST;
          busy_d     = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        state_d = CAPT;
      end
      CAPT: begin
        // Only the granted port's result registers change; the other port
        // keeps whatever it last returned.
        if (gnt_q) begin
          rsp1_z_d     = bus.ALU_Z;
          rsp1_flags_d = bus.ALU_FLAGS;
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_z_d     = bus.ALU_Z;
          rsp0_flags_d = bus.ALU_FLAGS;
          rsp0_valid_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_taken) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b1;
      busy_q       <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_inst_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_z_q     <= '0;
      rsp1_z_q     <= '0;
      rsp0_flags_q <= '0;
      rsp1_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_inst_q   <= alu_inst_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_z_q     <= rsp0_z_d;
      rsp1_z_q     <= rsp1_z_d;
      rsp0_flags_q <= rsp0_flags_d;
      rsp1_flags_q <= rsp1_flags_d;
    end
  end

  assign bus.REQ0_READY = ready0;
  assign bus.REQ1_READY = ready1;
  assign bus.RSP0_VALID = rsp0_valid_q;
  assign bus.RSP1_VALID = rsp1_valid_q;
  assign bus.RSP0_Z     = rsp0_z_q;
  assign bus.RSP1_Z     = rsp1_z_q;
  assign bus.RSP0_FLAGS = rsp0_flags_q;
  assign bus.RSP1_FLAGS = rsp1_flags_q;
  assign bus.ALU_A      = alu_a_q;
  assign bus.ALU_B      = alu_b_q;
  assign bus.ALU_INST   = alu_inst_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: stand-in registered ALU, directed sequence with
// randomized operands/opcodes/backpressure, checked against a transaction
// level model (expected result per accepted command, grant rule, latency).
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: last result seen per port, last granted port.
  logic [31:0] exp_z [2];
  logic [3:0]  exp_f [2];
  bit          model_last = 1'b1;

  // Stand-in ALU: flags {rsvd, zero, carry, ovf}; 0xE clears the result.
  function automatic logic [35:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] i);
    logic [32:0] s;
    logic [31:0] z;
    logic c;
    logic o;
    s = '0; c = 1'b0; o = 1'b0;
    case (i)
      4'h0: z = a & b;
      4'h1: z = a | b;
      4'h2: begin
        s = {1'b0, a} + {1'b0, b}; z = s[31:0]; c = s[32];
        o = (a[31] == b[31]) && (z[31] != a[31]);
      end
      4'h3: begin
        s = {1'b0, a} - {1'b0, b}; z = s[31:0]; c = s[32];
        o = (a[31] != b[31]) && (z[31] != a[31]);
      end
      4'hE: z = '0;
      default: z = a ^ b;
    endcase
    return {i[3], (z == 32'd0), c, o, z};
  endfunction

  always @(posedge clk) begin
    {bus.ALU_FLAGS, bus.ALU_Z} <= alu_f(bus.ALU_A, bus.ALU_B, bus.ALU_INST);
  end

  // Grant rule from the arbitration policy, not from the RTL.
  function automatic bit pick(bit v0, bit v1);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (v0 && v1) return ~model_last;
`endif
    return v0 ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(bit p, logic v, logic [31:0] a, logic [31:0] b, logic [3:0] i);
    if (p) begin
      bus.REQ1_VALID = v; bus.REQ1_A = a; bus.REQ1_B = b; bus.REQ1_INST = i;
    end else begin
      bus.REQ0_VALID = v; bus.REQ0_A = a; bus.REQ0_B = b; bus.REQ0_INST = i;
    end
  endtask

  task automatic drive_noise(logic v0, logic v1);
    drive_req(1'b0, v0, $urandom, $urandom, 4'($urandom));
    drive_req(1'b1, v1, $urandom, $urandom, 4'($urandom));
  endtask

  function automatic logic rdy(bit p);
    return p ? bus.REQ1_READY : bus.REQ0_READY;
  endfunction
  function automatic logic rv(bit p);
    return p ? bus.RSP1_VALID : bus.RSP0_VALID;
  endfunction
  function automatic logic [31:0] rz(bit p);
    return p ? bus.RSP1_Z : bus.RSP0_Z;
  endfunction
  function automatic logic [3:0] rf(bit p);
    return p ? bus.RSP1_FLAGS : bus.RSP0_FLAGS;
  endfunction

  task automatic set_rsp_ready(bit p, logic v);
    if (p) bus.RSP1_READY = v; else bus.RSP0_READY = v;
  endtask

  task automatic model_reset();
    exp_z[0] = '0; exp_z[1] = '0;
    exp_f[0] = '0; exp_f[1] = '0;
    model_last = 1'b1;
  endtask

  // One command from port p alone, response held off for bp cycles.
  task automatic single_cmd(bit p, logic [31:0] a, logic [31:0] b, logic [3:0] inst, int bp);
    logic [35:0] r;
    drive_req(p, 1'b1, a, b, inst);
    drive_req(~p, 1'b0, $urandom, $urandom, 4'($urandom));
    set_rsp_ready(p, 1'b0);
    set_rsp_ready(~p, 1'($urandom));
    #1;
    chk("idle_busy", bus.BUSY, 0);
    chk("acc_ready", rdy(p), 1);
    chk("acc_other_ready", rdy(~p), 0);
    model_last = p;
    r = alu_f(a, b, inst);

    step();  // EXEC
    drive_noise(1'($urandom), 1'($urandom));
    #1;
    chk("exec_busy", bus.BUSY, 1);
    chk("exec_alu_a", bus.ALU_A, a);
    chk("exec_alu_b", bus.ALU_B, b);
    chk("exec_alu_inst", bus.ALU_INST, inst);
    chk("exec_ready", {bus.REQ0_READY, bus.REQ1_READY}, 0);
    chk("exec_rsp_valid", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);

    step();  // CAPT
    drive_noise(1'($urandom), 1'($urandom));
    #1;
    chk("capt_alu_a", bus.ALU_A, a);
    chk("capt_ready", {bus.REQ0_READY, bus.REQ1_READY}, 0);
    chk("capt_rsp_valid", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);

    exp_z[p] = r[31:0];
    exp_f[p] = r[35:32];
    for (int i = 0; i <= bp; i++) begin
      step();  // RESP, t+3+i
      drive_noise(1'b1, 1'b1);
      set_rsp_ready(p, (i == bp));
      set_rsp_ready(~p, 1'($urandom));
      #1;
      chk("resp_valid", rv(p), 1);
      chk("resp_other_valid", rv(~p), 0);
      chk("resp_z", rz(p), exp_z[p]);
      chk("resp_flags", rf(p), exp_f[p]);
      chk("resp_other_z", rz(~p), exp_z[~p]);
      chk("resp_other_flags", rf(~p), exp_f[~p]);
      chk("resp_busy", bus.BUSY, 1);
      chk("resp_ready", {bus.REQ0_READY, bus.REQ1_READY}, 0);
    end

    step();  // back to IDLE
    drive_noise(1'b0, 1'b0);
    set_rsp_ready(p, 1'b0);
    #1;
    chk("done_busy", bus.BUSY, 0);
    chk("done_rsp_valid", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] r;
    logic [31:0] acc_a, acc_b, ra, rb;
    logic [3:0]  acc_i;
    bit          acc_g, g, p;
    int          idle_at, acc_c, n_acc, n_acc1, d;

    // Reset
    model_reset();
    drive_noise(1'b0, 1'b0);
    bus.RSP0_READY = 1'b0;
    bus.RSP1_READY = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_rsp_valid", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);
    chk("rst_ready", {bus.REQ0_READY, bus.REQ1_READY}, 0);
    chk("rst_rsp0_z", bus.RSP0_Z, 0);
    chk("rst_rsp1_z", bus.RSP1_Z, 0);
    chk("rst_flags", {bus.RSP0_FLAGS, bus.RSP1_FLAGS}, 0);
    chk("rst_alu_a", bus.ALU_A, 0);
    chk("rst_alu_b", bus.ALU_B, 0);
    chk("rst_alu_inst", bus.ALU_INST, 0);
    rst_n = 1'b1;
    step();

    // Port 0 ADD 5+7, immediate take
    single_cmd(1'b0, 32'h5, 32'h7, 4'h2, 0);
    chk("add_z_const", bus.RSP0_Z, 32'h0000000C);
    chk("add_zero_flag", bus.RSP0_FLAGS[2], 0);

    // Port 1 opcode 0xE: cleared result, zero flag set
    single_cmd(1'b1, 32'h1234, $urandom, 4'hE, 1);
    chk("clr_z_const", bus.RSP1_Z, 32'h0);
    chk("clr_zero_flag", bus.RSP1_FLAGS[2], 1);

    // Unsupported opcode 6 passes through
    single_cmd(1'b0, $urandom, $urandom, 4'h6, 0);

    // Five cycles of backpressure on port 0
    single_cmd(1'b0, $urandom, $urandom, 4'h2, 5);

    // Randomized singles
    for (int k = 0; k < 12; k++) begin
      p = 1'($urandom);
      single_cmd(p, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset during EXEC of a port 0 SUB
    ra = $urandom; rb = $urandom;
    drive_req(1'b0, 1'b1, ra, rb, 4'h3);
    drive_req(1'b1, 1'b0, '0, '0, '0);
    bus.RSP0_READY = 1'b1;
    #1;
    chk("sub_acc_ready", bus.REQ0_READY, 1);
    step();
    drive_noise(1'b0, 1'b0);
    #1;
    chk("sub_exec_busy", bus.BUSY, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", bus.BUSY, 0);
    chk("mid_rst_alu_a", bus.ALU_A, 0);
    chk("mid_rst_alu_b", bus.ALU_B, 0);
    chk("mid_rst_alu_inst", bus.ALU_INST, 0);
    chk("mid_rst_rsp0_z", bus.RSP0_Z, 0);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mid_rst_no_rsp", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);
      chk("mid_rst_idle", bus.BUSY, 0);
    end

    // Both requesters valid for 16 cycles, responses always taken
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;
    idle_at = 0; acc_c = -10; acc_g = 1'b0; n_acc = 0; n_acc1 = 0;
    acc_a = '0; acc_b = '0; acc_i = '0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) step();
      drive_noise(1'b1, 1'b1);
      #1;
      if (c == idle_at) begin
        g = pick(1'b1, 1'b1);
        chk("both_grant", rdy(g), 1);
        chk("both_loser", rdy(~g), 0);
        acc_g = g; acc_c = c;
        acc_a = g ? bus.REQ1_A : bus.REQ0_A;
        acc_b = g ? bus.REQ1_B : bus.REQ0_B;
        acc_i = g ? bus.REQ1_INST : bus.REQ0_INST;
        model_last = g;
        idle_at += 4;
        n_acc++;
        if (g) n_acc1++;
      end else begin
        chk("both_busy_ready", {bus.REQ0_READY, bus.REQ1_READY}, 0);
      end
      d = c - acc_c;
      chk("both_rsp_valid", rv(acc_g), (d == 3));
      chk("both_rsp_other", rv(~acc_g), 0);
      if (d == 3) begin
        r = alu_f(acc_a, acc_b, acc_i);
        exp_z[acc_g] = r[31:0];
        exp_f[acc_g] = r[35:32];
        chk("both_rsp_z", rz(acc_g), exp_z[acc_g]);
        chk("both_rsp_flags", rf(acc_g), exp_f[acc_g]);
      end
    end
    step();
    drive_noise(1'b0, 1'b0);
    #1;
    chk("both_done_busy", bus.BUSY, 0);
    chk("both_accepts", n_acc, 4);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    chk("both_port1_accepts", n_acc1, 2);
`else
    chk("both_port1_accepts", n_acc1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
